// File: rtl/rv32_instenc.sv
// Streaming RV32I instruction encoder: packs decoded fields into instruction words and expands LI.
// Optional immediate range checking is enabled by defining INSTENC_RANGE_CHK_EN.
module rv32_instenc #(
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic        out_err
);

    typedef enum logic {IDLE, EMIT2} state_t;

    state_t      state;
    logic        vld_p1;
    logic        last_p1;
    logic        err_p1;
    logic [31:0] instr_p1;
    logic [4:0]  rd_p1;
    logic [11:0] lo_p1;

    logic [31:0] enc_word;
    logic        enc_two;
    logic        enc_err;
    logic        rng_err;
    logic        li_fits;
    logic [19:0] li_hi;

    // Stage p0: combinational encode of the presented bundle
    // Adding 0x800 before the >>12 only carries into bit 12 when imm[11] is set.
    assign li_hi   = in_imm[31:12] + {19'd0, in_imm[11]};
    assign li_fits = (&in_imm[31:11]) || !(|in_imm[31:11]);

`ifdef INSTENC_RANGE_CHK_EN
    logic signed [31:0] imm_s;
    assign imm_s = in_imm;

    always_comb begin
        rng_err = 1'b0;
        case (in_fmt)
            3'd1, 3'd2: rng_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            3'd3:       rng_err = in_imm[0] || (imm_s < -32'sd4096) || (imm_s > 32'sd4094);
            3'd4:       rng_err = |in_imm[11:0];
            3'd5:       rng_err = in_imm[0] || (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574);
            default:    rng_err = 1'b0;
        endcase
    end
`else
    assign rng_err = 1'b0;
`endif

    always_comb begin
        enc_word = NOP_WORD;
        enc_two  = 1'b0;
        enc_err  = rng_err;
        case (in_fmt)
            3'd0: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            3'd1: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            3'd2: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            3'd3: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], in_opcode};
            3'd4: enc_word = {in_imm[31:12], in_rd, in_opcode};
            3'd5: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            3'd6: begin
                if (li_fits) begin
                    enc_word = {in_imm[11:0], 5'd0, 3'b000, in_rd, 7'h13};
                end else begin
                    enc_word = {li_hi, in_rd, 7'h37};
                    enc_two  = |in_imm[11:0];
                end
            end
            default: begin
                enc_word = NOP_WORD;
                enc_err  = 1'b1;
            end
        endcase
    end

    assign in_ready = !rst && (state == IDLE) && (!vld_p1 || out_ready);

    // Stage p1: output register and LI second-word sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            vld_p1   <= 1'b0;
            instr_p1 <= 32'd0;
            last_p1  <= 1'b0;
            err_p1   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        vld_p1   <= 1'b1;
                        instr_p1 <= enc_word;
                        last_p1  <= !enc_two;
                        err_p1   <= enc_err;
                        if (enc_two) begin
                            state <= EMIT2;
                            rd_p1 <= in_rd;
                            lo_p1 <= in_imm[11:0];
                        end
                    end else if (out_ready) begin
                        vld_p1 <= 1'b0;
                    end
                end
                EMIT2: begin
                    if (out_ready) begin
                        instr_p1 <= {lo_p1, rd_p1, 3'b000, rd_p1, 7'h13};
                        last_p1  <= 1'b1;
                        err_p1   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid = vld_p1;
    assign out_instr = instr_p1;
    assign out_last  = last_p1;
    assign out_err   = err_p1;

endmodule

// File: doc/rv32_instenc.md
Name: rv32_InstEnc

Overview:
- Streaming RV32I instruction encoder; the inverse of immediate generation and decode.
- Accepts decoded fields (format, opcode, registers, functs, a 32-bit immediate) and packs them into a 32-bit instruction word. Immediate bits are scattered per the RISC-V I/S/B/U/J layouts.
- Expands the LI pseudo-instruction into one or two words (ADDI, or LUI [+ADDI]).
- Used by the self-test program generator and the boot-ROM patcher, between the field source and the instruction-memory writer. Valid/ready handshake on both sides.

Parameters:
- NOP_WORD, 32'h00000013, word emitted for reserved format codes (ADDI x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle this cycle
- in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J 6=LI 7=reserved
- in_opcode  in  7  major opcode (ignored for LI)
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1 (ignored for U, J, LI)
- in_rs2  in  5  source register 2 (R, S, B only)
- in_funct3  in  3  funct3 (ignored for U, J, LI)
- in_funct7  in  7  funct7 (R only)
- in_imm  in  32  immediate as a signed byte-offset/value; U-type takes the full value with low 12 bits expected zero
- out_valid  out  1  out_instr valid
- out_ready  in  1  downstream accepts
- out_instr  out  32  encoded instruction
- out_last  out  1  last word of the current bundle
- out_err  out  1  bundle immediate unencodable (sidecar, qualified by out_valid)

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high on rst.
- Reset values: out_valid=0, out_instr=0, out_last=0, out_err=0, state=IDLE. in_ready is combinational and equals 0 while rst is asserted. A reset in the middle of an LI pair discards the pending second word.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Handshake: accept when in_valid && in_ready. Output holds stable while out_valid && !out_ready.
- Latency: a bundle accepted at cycle N produces its first word with out_valid=1 at N+1. Full throughput of 1 word/cycle for non-LI bundles.
- Packing:
  - R: {funct7,rs2,rs1,f3,rd,opc}
  - I: {imm[11:0],rs1,f3,rd,opc}
  - S: {imm[11:5],rs2,rs1,f3,imm[4:0],opc}
  - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],opc}
  - U: {imm[31:12],rd,opc}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opc}
- LI expansion:
  - lo = sign-extended imm[11:0]; hi = (imm + 32'h800) >> 12, 20 bits, wrap-around permitted.
  - If imm fits in 12-bit signed: single word ADDI rd,x0,imm, with out_last=1.
  - Else if lo==0: single word LUI rd,hi, with out_last=1.
  - Else: LUI rd,hi (out_last=0), then ADDI rd,rd,lo (out_last=1).
- State machine:
  - IDLE: on an LI bundle needing two words, latch rd and lo and go to EMIT2.
  - EMIT2: load the ADDI word when the LUI word is taken (out_ready). Return to IDLE on that same transfer. in_ready stays 0 throughout EMIT2.
- Reserved fmt=7: emit NOP_WORD with out_last=1 and out_err=1.
- Simultaneous events: output taken and a new input accepted in the same cycle replaces the register with no bubble.

Optional Feature:
- Macro: INSTENC_RANGE_CHK_EN.
- Defined: out_err=1 on the word(s) of a bundle when the immediate is unencodable. The word is still emitted with truncated bits. Error conditions:
  - I/S: imm outside [-2048, 2047].
  - B: imm odd, or outside [-4096, 4094].
  - J: imm odd, or outside [-1048576, 1048574].
  - U: imm[11:0] != 0.
  - LI never raises out_err.
- Not defined: no range checks; imm bits are silently truncated. out_err is asserted only for fmt=7.

Test Plan:
- I-type, opc=0x13, rd=1, rs1=0, f3=0, imm=0xFFFFFFFF -> one word 0xFFF00093, out_last=1, out_err=0, one cycle after accept.
- S-type SW, opc=0x23, f3=2, rs1=3, rs2=2, imm=8 -> 0x0021A423. B-type BEQ x0,x0, imm=-4 -> 0xFE000EE3.
- LI rd=5, imm=0x12345FFF -> 0x123462B7 (last=0), then 0xFFF28293 (last=1). in_ready=0 until the second word is taken. Hold out_ready=0 for 3 cycles between words: the words stay stable.
- LI rd=1, imm=100 -> single 0x06400093. LI rd=1, imm=0x1000 -> single 0x000010B7. Back-to-back non-LI bundles with out_ready=1 -> one word per cycle.
- With INSTENC_RANGE_CHK_EN: J imm=0x00100000 -> out_err=1. B imm=3 -> out_err=1. fmt=7 -> 0x00000013 with out_err=1.
- Assert rst while in EMIT2 -> next cycle out_valid=0 and state IDLE; the pending ADDI is never emitted.
